// File: rtl/bp_me_clint_arbiter.sv
// Round-robin arbiter sharing one CLINT slice BedRock mem port among num_req_p requesters.
// Define BP_CLINT_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module bp_me_clint_arbiter #(
  parameter int unsigned num_req_p      = 4,
  parameter int unsigned header_width_p = 128,
  parameter int unsigned data_width_p   = 64
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic [num_req_p*header_width_p-1:0]   req_cmd_header_i,
  input  logic [num_req_p*data_width_p-1:0]     req_cmd_data_i,
  input  logic [num_req_p-1:0]                  req_cmd_v_i,
  output logic [num_req_p-1:0]                  req_cmd_ready_and_o,
  input  logic [num_req_p-1:0]                  req_cmd_last_i,
  output logic [num_req_p*header_width_p-1:0]   req_resp_header_o,
  output logic [num_req_p*data_width_p-1:0]     req_resp_data_o,
  output logic [num_req_p-1:0]                  req_resp_v_o,
  input  logic [num_req_p-1:0]                  req_resp_ready_and_i,
  output logic [num_req_p-1:0]                  req_resp_last_o,
  output logic [header_width_p-1:0]             mem_cmd_header_o,
  output logic [data_width_p-1:0]               mem_cmd_data_o,
  output logic                                  mem_cmd_v_o,
  output logic                                  mem_cmd_last_o,
  input  logic                                  mem_cmd_ready_and_i,
  input  logic [header_width_p-1:0]             mem_resp_header_i,
  input  logic [data_width_p-1:0]               mem_resp_data_i,
  input  logic                                  mem_resp_v_i,
  input  logic                                  mem_resp_last_i,
  output logic                                  mem_resp_ready_and_o,
  output logic [$clog2(num_req_p)-1:0]          grant_id_o
);

  localparam int unsigned ID_W = $clog2(num_req_p);

  typedef enum logic [1:0] {e_idle, e_cmd, e_resp} state_e;

  state_e          r_state;
  logic [ID_W-1:0] r_rr_ptr;
  logic [ID_W-1:0] r_grant_id;

  logic [ID_W-1:0] w_idx;
  logic [ID_W-1:0] w_pick;
  logic            w_any;
  logic [ID_W-1:0] w_next_ptr;
  logic            w_cmd_done;
  logic            w_resp_done;

  // First valid requester at or after the round-robin pointer, wrapping
  always_comb begin
    w_idx  = '0;
    w_pick = '0;
    w_any  = 1'b0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      w_idx = ID_W'((32'(r_rr_ptr) + i) % num_req_p);
      if (!w_any && req_cmd_v_i[w_idx]) begin
        w_any  = 1'b1;
        w_pick = w_idx;
      end
    end
  end

  // Route the granted requester's streams; all handshakes gated by state
  always_comb begin
    mem_cmd_header_o     = '0;
    mem_cmd_data_o       = '0;
    mem_cmd_v_o          = 1'b0;
    mem_cmd_last_o       = 1'b0;
    req_cmd_ready_and_o  = '0;
    req_resp_v_o         = '0;
    req_resp_last_o      = '0;
    mem_resp_ready_and_o = 1'b0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      if (ID_W'(i) == r_grant_id) begin
        mem_cmd_header_o = req_cmd_header_i[i*header_width_p +: header_width_p];
        mem_cmd_data_o   = req_cmd_data_i[i*data_width_p +: data_width_p];
        if (r_state == e_cmd) begin
          mem_cmd_v_o            = req_cmd_v_i[i];
          mem_cmd_last_o         = req_cmd_last_i[i];
          req_cmd_ready_and_o[i] = mem_cmd_ready_and_i;
        end
        if (r_state == e_resp) begin
          req_resp_v_o[i]      = mem_resp_v_i;
          req_resp_last_o[i]   = mem_resp_last_i;
          mem_resp_ready_and_o = req_resp_ready_and_i[i];
        end
      end
    end
  end

  assign req_resp_header_o = {num_req_p{mem_resp_header_i}};
  assign req_resp_data_o   = {num_req_p{mem_resp_data_i}};
  assign grant_id_o        = r_grant_id;

  assign w_cmd_done  = mem_cmd_v_o & mem_cmd_ready_and_i & mem_cmd_last_o;
  assign w_resp_done = mem_resp_v_i & mem_resp_ready_and_o & mem_resp_last_i;

`ifdef BP_CLINT_ARB_FIXED_PRIO_EN
  assign w_next_ptr = '0;
`else
  assign w_next_ptr = (r_grant_id == ID_W'(num_req_p - 1)) ? '0 : r_grant_id + 1'b1;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state    <= e_idle;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
    end else begin
      case (r_state)
        e_idle: if (w_any) begin
          r_grant_id <= w_pick;
          r_state    <= e_cmd;
        end
        e_cmd: if (w_cmd_done) r_state <= e_resp;
        e_resp: if (w_resp_done) begin
          r_rr_ptr <= w_next_ptr;
          r_state  <= e_idle;
        end
        default: r_state <= e_idle;
      endcase
    end
  end

endmodule

// File: doc/bp_me_clint_arbiter.md
# bp_me_clint_arbiter

Round-robin arbiter that shares one CLINT slice BedRock mem port among `num_req_p` requesters (e.g. per-core I/O paths plus the debug path). Each transaction is granted exclusively: the grant is held from the first command beat until the last response beat, so responses always return to the issuing requester without tagging. Sits between the requester-side BedRock streams and the CLINT slice's `mem_cmd`/`mem_resp` ports.

## Interface
- `num_req_p`, 4, number of requesters (2..16)
- `header_width_p`, 128, BedRock mem header width (opaque to this block)
- `data_width_p`, 64, data beat width
- `clk_i`  in  1  core clock
- `reset_i`  in  1  asynchronous, active-high reset
- `req_cmd_header_i`  in  num_req_p x header_width_p  per-requester command header
- `req_cmd_data_i`  in  num_req_p x data_width_p  per-requester command data
- `req_cmd_v_i`  in  num_req_p  command valid
- `req_cmd_ready_and_o`  out  num_req_p  command ready
- `req_cmd_last_i`  in  num_req_p  last command beat
- `req_resp_header_o`  out  num_req_p x header_width_p  response header (broadcast)
- `req_resp_data_o`  out  num_req_p x data_width_p  response data (broadcast)
- `req_resp_v_o`  out  num_req_p  response valid (granted requester only)
- `req_resp_ready_and_i`  in  num_req_p  response ready
- `req_resp_last_o`  out  num_req_p  last response beat
- `mem_cmd_header_o` / `mem_cmd_data_o` / `mem_cmd_v_o` / `mem_cmd_last_o`  out  header/data/1/1  to CLINT slice
- `mem_cmd_ready_and_i`  in  1  CLINT command ready
- `mem_resp_header_i` / `mem_resp_data_i` / `mem_resp_v_i` / `mem_resp_last_i`  in  header/data/1/1  from CLINT slice
- `mem_resp_ready_and_o`  out  1  CLINT response ready
- `grant_id_o`  out  clog2(num_req_p)  current/last granted requester (debug)

## Operation
- FSM states: `e_idle`, `e_cmd`, `e_resp`.
- `e_idle`: all ready/valid outputs 0. If any `req_cmd_v_i`, select first asserted index at or after `rr_ptr_r` (wrapping); register `grant_id_r`, go `e_cmd`.
- `e_cmd`: granted requester's cmd bus passed combinationally to `mem_cmd_*_o`; `req_cmd_ready_and_o[grant]` = `mem_cmd_ready_and_i`; others 0. On handshake with `last` asserted -> `e_resp`.
- `e_resp`: `mem_resp_*` passed to granted requester; `mem_resp_ready_and_o` = `req_resp_ready_and_i[grant]`; other `req_resp_v_o` bits 0. On handshake with `mem_resp_last_i` -> `e_idle`, `rr_ptr_r` <= grant+1 (wrap at `num_req_p`).
- Requester deasserting valid mid-transaction does not revoke grant; arbiter waits.
- Responses arriving while in `e_idle`/`e_cmd` are not accepted (`mem_resp_ready_and_o`=0).
- Header/data content never modified.

## Timing
- Reset: FSM `e_idle`, `rr_ptr_r`=0, `grant_id_r`=0; all `*_v_o`, `*_ready_and_o`, `*_last_o` = 0 while reset asserted and the cycle after.
- Arbitration bubble: 1 cycle (request seen in cycle N, forwarded to CLINT in N+1).
- Cmd/resp paths zero-latency pass-through once granted.
- Back-to-back: after last resp handshake in cycle M, next grant decided in M+1, forwarded in M+2.
- Reset mid-transaction: immediate return to `e_idle`; in-flight transaction dropped (CLINT reset concurrently).

## Configuration
- `BP_CLINT_ARB_FIXED_PRIO_EN`: defined -> fixed priority, lowest index wins, `rr_ptr_r` held at 0. Undefined (default) -> round-robin as above.

## Test plan
- Reset then single requester 2 write mtimecmp=0x100 -> grant in cycle 1 after valid, one cmd beat to CLINT, response returned only on `req_resp_v_o[2]`, `grant_id_o`=2.
- All 4 requesters continuously valid -> grant order 0,1,2,3,0; with FIXED_PRIO_EN order 0,0,0,….
- CLINT holds `mem_resp_v_i` low 20 cycles -> requester 1 waiting on cmd stays unready, no second grant issued.
- Requester holds `req_resp_ready_and_i` low 5 cycles -> `mem_resp_ready_and_o`=0 for those cycles, data stable, completes on 6th.
- Two-beat command (`last` on beat 2) -> state stays `e_cmd` after beat 1, moves to `e_resp` after beat 2.
- Assert `reset_i` in `e_resp` -> all valids 0 immediately, next request after reset granted to requester 0.
